// File: rtl/spectrum_pkg.sv
// Shared defaults, FSM encoding and bar-height helpers for the spectrum display reader.
package spectrum_pkg;

  localparam int unsigned DefaultBins   = 256;
  localparam int unsigned DefaultLenW   = 11;
  localparam int unsigned DefaultMaxLen = 1000;

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StSwap} state_e;

  typedef logic [$clog2(DefaultBins)-1:0] bin_idx_t;
  typedef logic [DefaultLenW-1:0]         bar_len_t;

  // Shift first, then clamp, so large words saturate instead of wrapping.
  function automatic int unsigned clamp_len(input logic [63:0] word, input int unsigned shift,
                                            input int unsigned max_len);
    logic [63:0] scaled;
    scaled = word >> shift;
    if (scaled > 64'(max_len)) return max_len;
    return scaled[31:0];
  endfunction

endpackage

// File: rtl/spectrum_bin_ram.sv
// Two-bank simple dual-port bin RAM: one write port, one registered read port.
module spectrum_bin_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 11,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             pixel_clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [AddrW-1:0] wr_addr,
  input  logic [Width-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [AddrW-1:0] rd_addr,
  output logic [Width-1:0] rd_data
);

  logic [Width-1:0] mem [2*Depth];

  always_ff @(posedge pixel_clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/spectrum_fifo_reader.sv
// Pops one spectrum frame per data_req into the inactive RAM bank, then swaps banks.
// Optional peak-hold with decay is enabled by defining SPECTRUM_PEAK_HOLD_EN.
module spectrum_fifo_reader
  import spectrum_pkg::*;
#(
  parameter int unsigned BINS    = DefaultBins,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LEN_W   = DefaultLenW,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned MAX_LEN = DefaultMaxLen,
  parameter int unsigned DECAY   = 4
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              data_req,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_req,
  input  logic [15:0]       line_cnt,
  output logic [DATA_W-1:0] line_length,
  output logic              wr_over,
  output logic              busy,
  output logic              req_drop
);

  localparam int unsigned IdxW = $clog2(BINS);
  localparam logic [IdxW:0] BinsIdx = BINS[IdxW:0];

  if (MAX_LEN >= (1 << LEN_W) || DECAY >= (1 << LEN_W)) begin : g_bad_cfg
    $error("MAX_LEN and DECAY must fit in LEN_W bits");
  end

  state_e            state_q, state_d;
  logic [IdxW:0]     rd_idx_q, rd_idx_d, wr_idx_q, wr_idx_d;
  logic              cap_q, bank_q, frame_valid_q, req_drop_q, rd_ok_q;
  logic              pop, cap_last;
  logic [LEN_W-1:0]  h, stored, ram_rd_data;

  assign pop      = (state_q == StLoad) && !fifo_empty && (rd_idx_q < BinsIdx);
  assign cap_last = cap_q && (wr_idx_q[IdxW-1:0] == '1);
  assign h        = LEN_W'(clamp_len(64'(fifo_rd_data), SHIFT, MAX_LEN));

  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    wr_idx_d    = wr_idx_q;
    fifo_rd_req = 1'b0;
    wr_over     = 1'b0;
    case (state_q)
      StIdle: begin
        if (data_req) begin
          state_d  = StLoad;
          rd_idx_d = '0;
          wr_idx_d = '0;
        end
      end
      StLoad: begin
        fifo_rd_req = pop;
        if (pop) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == BinsIdx - 1'b1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (cap_last) state_d = StSwap;
      end
      StSwap: begin
        wr_over = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // FIFO data lands one cycle after the pop; cap_q marks that capture slot.
    if (cap_q) wr_idx_d = wr_idx_q + 1'b1;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rd_idx_q      <= '0;
      wr_idx_q      <= '0;
      cap_q         <= 1'b0;
      bank_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      req_drop_q    <= 1'b0;
      rd_ok_q       <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      cap_q    <= pop;
      if (state_q == StSwap) begin
        bank_q        <= ~bank_q;
        frame_valid_q <= 1'b1;
      end
      if (data_req && state_q != StIdle) req_drop_q <= 1'b1;
      rd_ok_q <= frame_valid_q && (32'(line_cnt) < BINS);
    end
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  localparam logic [LEN_W-1:0] DecayLen = LEN_W'(DECAY);

  logic [LEN_W-1:0] peak_mem [BINS];
  logic [LEN_W-1:0] peak_rd_q, peak_prev, peak_dec;

  always_ff @(posedge pixel_clk) begin
    if (pop)   peak_rd_q <= peak_mem[rd_idx_q[IdxW-1:0]];
    if (cap_q) peak_mem[wr_idx_q[IdxW-1:0]] <= stored;
  end

  // Peak memory is never cleared; until the first swap it is treated as zero.
  always_comb begin
    peak_prev = frame_valid_q ? peak_rd_q : '0;
    peak_dec  = (peak_prev >= DecayLen) ? peak_prev - DecayLen : '0;
    stored    = (h > peak_dec) ? h : peak_dec;
  end
`else
  assign stored = h;
`endif

  spectrum_bin_ram #(
    .Depth(BINS),
    .Width(LEN_W),
    .AddrW(IdxW)
  ) u_bin_ram (
    .pixel_clk(pixel_clk),
    .wr_en    (cap_q),
    .wr_bank  (~bank_q),
    .wr_addr  (wr_idx_q[IdxW-1:0]),
    .wr_data  (stored),
    .rd_bank  (bank_q),
    .rd_addr  (line_cnt[IdxW-1:0]),
    .rd_data  (ram_rd_data)
  );

  assign line_length = rd_ok_q ? DATA_W'(ram_rd_data) : '0;
  assign busy        = (state_q != StIdle);
  assign req_drop    = req_drop_q;

endmodule

// File: tb/tb_spectrum_fifo_reader.sv
// Bench for spectrum_fifo_reader: FIFO queue model plus a frame-level reference model.
module tb_spectrum_fifo_reader;

  localparam int unsigned BINS    = 256;
  localparam int unsigned SHIFT   = 8;
  localparam int unsigned MAX_LEN = 1000;
  localparam int unsigned DECAY   = 4;

  logic        pixel_clk = 1'b0;
  logic        rst, data_req, fifo_empty, fifo_rd_req, wr_over, busy, req_drop;
  logic [31:0] fifo_rd_data, line_length;
  logic [15:0] line_cnt;

  always #5 pixel_clk = ~pixel_clk;

  spectrum_fifo_reader dut (
    .pixel_clk   (pixel_clk),
    .rst         (rst),
    .data_req    (data_req),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_req (fifo_rd_req),
    .line_cnt    (line_cnt),
    .line_length (line_length),
    .wr_over     (wr_over),
    .busy        (busy),
    .req_drop    (req_drop)
  );

  typedef struct {
    logic [15:0] lc;
    logic [31:0] word;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[12];
  logic [31:0] fifo_q[$];
  logic [31:0] wbuf[BINS];
  bit          hold_empty;
  int          pops;
  int          n_chk, n_pass;
  int          shown[BINS], pending[BINS], peak[BINS];
  bit          mvalid;
  int          lat, bound;
  int          peak_exp[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  function automatic int scale(input logic [31:0] w);
    longint unsigned v;
    v = w / (2 ** SHIFT);
    return (v > MAX_LEN) ? MAX_LEN : int'(v);
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 300000);
      2:       return 32'hFFFF_FFFF;
      default: return $urandom_range(250000, 260000);
    endcase
  endfunction

  // Push wbuf into the FIFO and work out what the display should show once it lands.
  task automatic queue_frame();
    int h, d;
    for (int i = 0; i < BINS; i++) begin
      fifo_q.push_back(wbuf[i]);
      h = scale(wbuf[i]);
`ifdef SPECTRUM_PEAK_HOLD_EN
      d = mvalid ? peak[i] - int'(DECAY) : 0;
      if (d < 0) d = 0;
      pending[i] = (h > d) ? h : d;
`else
      d = 0;
      pending[i] = h + d;
`endif
    end
  endtask

  task automatic model_reset();
    mvalid = 1'b0;
    fifo_q.delete();
    for (int i = 0; i < BINS; i++) peak[i] = 0;
  endtask

  task automatic tick();
    logic req;
    logic [31:0] word;
    bit got;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
    req = fifo_rd_req;
    if (fifo_empty) check("rd_req_while_empty", {31'd0, fifo_rd_req}, 32'd0);
    got = 1'b0;
    @(posedge pixel_clk);
    if (req && fifo_q.size() > 0) begin
      word = fifo_q.pop_front();
      got  = 1'b1;
      pops++;
    end
    #1;
    if (got) fifo_rd_data = word;
    fifo_empty = hold_empty || (fifo_q.size() == 0);
    #1;
  endtask

  // One clock: predict line_length for this line_cnt, commit frames on wr_over, compare.
  task automatic step();
    logic [31:0] e;
    e = (mvalid && line_cnt < BINS) ? 32'(shown[line_cnt]) : 32'd0;
    if (wr_over === 1'b1) begin
      for (int i = 0; i < BINS; i++) begin
        shown[i] = pending[i];
        peak[i]  = pending[i];
      end
      mvalid = 1'b1;
    end
    tick();
    check("line_length", line_length, e);
  endtask

  task automatic run_load(input int gap_at, input int gap_len, input int drop_at, input bit rnd,
                          input int exp_lat, output int lat_o);
    int gap_end;
    gap_end  = -1;
    pops     = 0;
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    lat_o    = 1;
    while (wr_over !== 1'b1 && lat_o < 3000) begin
      check("busy_during_load", {31'd0, busy}, 32'd1);
      line_cnt = 16'($urandom_range(0, 299));
      if (rnd) hold_empty = ($urandom_range(0, 3) == 0);
      else begin
        if (gap_at >= 0 && gap_end < 0 && pops == gap_at) gap_end = lat_o + gap_len;
        hold_empty = (gap_end >= 0) && (lat_o < gap_end);
      end
      data_req = (lat_o == drop_at);
      step();
      lat_o++;
    end
    data_req   = 1'b0;
    hold_empty = 1'b0;
    check("wr_over_seen", {31'd0, wr_over}, 32'd1);
    check("busy_at_wr_over", {31'd0, busy}, 32'd1);
    check("pop_count", 32'(pops), 32'(BINS));
    if (exp_lat > 0) check("wr_over_latency", 32'(lat_o), 32'(exp_lat));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, required self-finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'd10,    32'd10000,       32'd39};
    vecs[1]  = '{16'd255,   32'd255000,      32'd996};
    vecs[2]  = '{16'd3,     32'hFFFF_FFFF,   32'd1000};
    vecs[3]  = '{16'd0,     32'd0,           32'd0};
    vecs[4]  = '{16'd1,     32'd255,         32'd0};
    vecs[5]  = '{16'd2,     32'd256,         32'd1};
    vecs[6]  = '{16'd4,     32'd256000,      32'd1000};
    vecs[7]  = '{16'd5,     32'd256256,      32'd1000};
    vecs[8]  = '{16'd6,     32'h0003_E7FF,   32'd999};
    vecs[9]  = '{16'd300,   32'd0,           32'd0};
    vecs[10] = '{16'd256,   32'd0,           32'd0};
    vecs[11] = '{16'd65535, 32'd0,           32'd0};
`ifdef SPECTRUM_PEAK_HOLD_EN
    peak_exp = '{200, 196, 192};
`else
    peak_exp = '{200, 0, 0};
`endif

    n_chk = 0; n_pass = 0; pops = 0;
    rst = 1'b1; data_req = 1'b0; hold_empty = 1'b0; line_cnt = '0;
    fifo_rd_data = '0; fifo_empty = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state and idle behaviour.
    check("rst_fifo_rd_req", {31'd0, fifo_rd_req}, 32'd0);
    check("rst_wr_over", {31'd0, wr_over}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_req_drop", {31'd0, req_drop}, 32'd0);
    check("rst_line_length", line_length, 32'd0);
    line_cnt = 16'd5;
    step();
    check("reset_read_5", line_length, 32'd0);

    // Directed frame from the vector table.
    for (int i = 0; i < BINS; i++) wbuf[i] = 32'(i * 1000);
    foreach (vecs[k]) if (vecs[k].lc < BINS) wbuf[vecs[k].lc] = vecs[k].word;
    queue_frame();
    repeat (3) begin
      step();
      check("no_req_idle", {31'd0, fifo_rd_req}, 32'd0);
    end
    check("no_pops_idle", 32'(pops), 32'd0);
    run_load(-1, 0, -1, 1'b0, 258, lat);
    step();
    check("busy_after_swap", {31'd0, busy}, 32'd0);
    foreach (vecs[k]) begin
      line_cnt = vecs[k].lc;
      step();
      check($sformatf("vec%0d_lc%0d", k, vecs[k].lc), line_length, vecs[k].exp);
    end

    // 20-cycle empty gap at pop 100 plus a data_req during LOAD.
    for (int i = 0; i < BINS; i++) wbuf[i] = rand_word();
    queue_frame();
    run_load(100, 20, 50, 1'b0, 278, lat);
    check("req_drop_set", {31'd0, req_drop}, 32'd1);
    step();
    for (int i = 0; i < BINS; i++) begin
      line_cnt = 16'(i);
      step();
    end

    // Reset at pop 100.
    for (int i = 0; i < BINS; i++) wbuf[i] = rand_word();
    queue_frame();
    pops = 0; data_req = 1'b1;
    step();
    data_req = 1'b0; line_cnt = 16'd10; bound = 0;
    while (pops < 100 && bound < 1000) begin
      step();
      bound++;
    end
    check("reached_pop_100", 32'(pops), 32'd100);
    rst = 1'b1;
    #1;
    check("arst_fifo_rd_req", {31'd0, fifo_rd_req}, 32'd0);
    check("arst_wr_over", {31'd0, wr_over}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_req_drop", {31'd0, req_drop}, 32'd0);
    check("arst_line_length", line_length, 32'd0);
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();
    check("post_reset_read", line_length, 32'd0);
    check("post_reset_busy", {31'd0, busy}, 32'd0);

    // Bin 7 peak sequence: 200, then zeros.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < BINS; i++) wbuf[i] = '0;
      if (f == 0) wbuf[7] = 32'd200 * 256;
      queue_frame();
      run_load(-1, 0, -1, 1'b0, 258, lat);
      step();
      line_cnt = 16'd7;
      step();
      check($sformatf("peak_frame%0d", f + 1), line_length, 32'(peak_exp[f]));
    end

    // Randomized frames with random FIFO stalls and reads.
    check("req_drop_cleared", {31'd0, req_drop}, 32'd0);
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < BINS; i++) wbuf[i] = rand_word();
      queue_frame();
      run_load(-1, 0, -1, 1'b1, -1, lat);
      if (f == 0) begin
        data_req = 1'b1;
        step();
        data_req = 1'b0;
        check("drop_at_wr_over", {31'd0, req_drop}, 32'd1);
        step();
        check("no_restart", {31'd0, busy}, 32'd0);
      end else begin
        step();
      end
      repeat (30) begin
        line_cnt = 16'($urandom_range(0, 511));
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
